// File: rtl/jt6295_fetch_pkg.sv
// jt6295_fetch_pkg: fetch FSM state encodings and nibble ordering shared by the fetcher
package jt6295_fetch_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_EMIT = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;
  function automatic logic [3:0] pick_nib(input logic [7:0] b, input logic sel);
    return sel ? b[3:0] : b[7:4];
  endfunction
endpackage

// File: rtl/jt6295_fetch_chptr.sv
// jt6295_fetch_chptr: per-channel phrase pointer, end, nibble select, first flag and busy
module jt6295_fetch_chptr #(
  parameter int AW = 18
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  input  logic          hold,
  input  logic          emit,
  output logic          busy,
  output logic          sel,
  output logic          first,
  output logic [AW-1:0] ptr
);
  logic st_prev, sp_prev, st_pend;
  logic [AW-1:0] end_r, pst_addr, pend_addr;
  wire st_edge = start & ~st_prev;
  wire sp_edge = stop & ~sp_prev;
  // a start landing on the channel under service is parked until the FSM moves on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_prev   <= 1'b0;
      sp_prev   <= 1'b0;
      st_pend   <= 1'b0;
      busy      <= 1'b0;
      sel       <= 1'b0;
      first     <= 1'b0;
      ptr       <= '0;
      end_r     <= '0;
      pst_addr  <= '0;
      pend_addr <= '0;
    end else begin
      st_prev <= start;
      sp_prev <= stop;
      if (st_edge && !hold) begin
        ptr     <= start_addr;
        end_r   <= end_addr;
        sel     <= 1'b0;
        first   <= 1'b1;
        busy    <= 1'b1;
        st_pend <= 1'b0;
      end else if (st_pend && !hold && !sp_edge) begin
        ptr     <= pst_addr;
        end_r   <= pend_addr;
        sel     <= 1'b0;
        first   <= 1'b1;
        busy    <= 1'b1;
        st_pend <= 1'b0;
      end else begin
        if (st_edge) begin
          st_pend   <= 1'b1;
          pst_addr  <= start_addr;
          pend_addr <= end_addr;
        end else if (sp_edge) st_pend <= 1'b0;
        if (sp_edge && !st_edge) busy <= 1'b0;
        else if (emit) begin
          first <= 1'b0;
          sel   <= ~sel;
          if (sel && ptr == end_r) busy <= 1'b0;
          else if (sel) ptr <= ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/jt6295_fetch.sv
// jt6295_fetch: round-robin ADPCM ROM fetcher streaming tagged nibbles, one per busy channel per sample
module jt6295_fetch
  import jt6295_fetch_pkg::*;
#(
  parameter int AW  = 18,
  parameter int NCH = 4
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen_sr,
  input  logic [3:0]    start,
  input  logic [3:0]    stop,
  input  logic [AW-1:0] start_addr0,
  input  logic [AW-1:0] start_addr1,
  input  logic [AW-1:0] start_addr2,
  input  logic [AW-1:0] start_addr3,
  input  logic [AW-1:0] end_addr0,
  input  logic [AW-1:0] end_addr1,
  input  logic [AW-1:0] end_addr2,
  input  logic [AW-1:0] end_addr3,
  output logic [3:0]    busy,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    nib,
  output logic [1:0]    nib_ch,
  output logic          nib_vld,
  output logic          nib_first,
  output logic          frame_done,
  output logic          overrun
);
  logic [2:0] state;
  logic [1:0] ch;
  logic pend;
  logic [NCH-1:0] sel, first, hold, emit;
  logic [AW-1:0] ptr [NCH];
  logic [AW-1:0] sa [NCH];
  logic [AW-1:0] ea [NCH];
  logic [7:0] byte_buf [NCH];
  assign sa = '{start_addr0, start_addr1, start_addr2, start_addr3};
  assign ea = '{end_addr0, end_addr1, end_addr2, end_addr3};
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign hold[i] = ch == 2'(i) && (state == S_SCAN || state == S_REQ || state == S_WAIT || state == S_EMIT);
    assign emit[i] = hold[i] && state == S_EMIT && busy[i];
    jt6295_fetch_chptr #(.AW(AW)) u_chptr (
      .rst(rst), .clk(clk), .start(start[i]), .stop(stop[i]),
      .start_addr(sa[i]), .end_addr(ea[i]), .hold(hold[i]), .emit(emit[i]),
      .busy(busy[i]), .sel(sel[i]), .first(first[i]), .ptr(ptr[i])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ch         <= 2'd0;
      pend       <= 1'b0;
      overrun    <= 1'b0;
      rom_addr   <= '0;
      rom_cs     <= 1'b0;
      nib        <= 4'd0;
      nib_ch     <= 2'd0;
      nib_vld    <= 1'b0;
      nib_first  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < NCH; k++) byte_buf[k] <= 8'd0;
    end else begin
      nib_vld    <= 1'b0;
      frame_done <= 1'b0;
      pend       <= cen_sr | (pend & (state != S_IDLE));
      if (cen_sr && pend) overrun <= 1'b1;
      case (state)
        S_IDLE: if (pend) begin
          ch    <= 2'd0;
          state <= S_SCAN;
        end
        S_SCAN: state <= !busy[ch] ? S_NEXT : sel[ch] ? S_EMIT : S_REQ;
        S_REQ: begin
          rom_addr <= ptr[ch];
          rom_cs   <= 1'b1;
          state    <= S_WAIT;
        end
        // a channel stopped during the read still completes the access but drops the byte
        S_WAIT: if (rom_ok) begin
          rom_cs       <= 1'b0;
          byte_buf[ch] <= rom_data;
          state        <= busy[ch] ? S_EMIT : S_NEXT;
        end
        S_EMIT: begin
          nib_vld   <= busy[ch];
          nib       <= pick_nib(byte_buf[ch], sel[ch]);
          nib_ch    <= ch;
          nib_first <= first[ch];
          state     <= S_NEXT;
        end
        S_NEXT: begin
          frame_done <= ch == 2'd3;
          ch         <= ch + 2'd1;
          state      <= ch == 2'd3 ? S_IDLE : S_SCAN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jt6295_fetch.sv
// tb_jt6295_fetch: directed stimulus with a nibble scoreboard checked by an independent monitor
module tb_jt6295_fetch;
  localparam int AW = 18;
  typedef struct packed {logic [1:0] ch; logic [3:0] n; logic f;} exp_t;
  logic rst = 1'b1, clk = 1'b0, cen_sr = 1'b0, rom_ok = 1'b0;
  logic [3:0] start = '0, stop = '0;
  logic [AW-1:0] sa [4];
  logic [AW-1:0] ea [4];
  logic [7:0] rom_data = 8'd0;
  logic [3:0] busy, nib;
  logic [AW-1:0] rom_addr;
  logic [1:0] nib_ch;
  logic rom_cs, nib_vld, nib_first, frame_done, overrun;
  exp_t q[$];
  exp_t e_m;
  int n_chk = 0, n_fail = 0, rom_lat = 2, rom_cnt = 0;
  logic [7:0] mem [int];

  jt6295_fetch #(.AW(AW), .NCH(4)) dut (
    .rst(rst), .clk(clk), .cen_sr(cen_sr), .start(start), .stop(stop),
    .start_addr0(sa[0]), .start_addr1(sa[1]), .start_addr2(sa[2]), .start_addr3(sa[3]),
    .end_addr0(ea[0]), .end_addr1(ea[1]), .end_addr2(ea[2]), .end_addr3(ea[3]),
    .busy(busy), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .nib(nib), .nib_ch(nib_ch), .nib_vld(nib_vld), .nib_first(nib_first),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (nib_vld) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL nib_unexpected: got ch=%0d nib=%0h first=%0b expected none", nib_ch, nib, nib_first);
      end else begin
        e_m = q.pop_front();
        check("nib{ch,nib,first}", 32'({nib_ch, nib, nib_first}), 32'(e_m));
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rom_ok) begin
      rom_ok = 1'b0;
      rom_cnt = 0;
    end else if (rom_cs) begin
      rom_cnt++;
      if (rom_cnt >= rom_lat) begin
        rom_ok = 1'b1;
        rom_data = mem.exists(int'(rom_addr)) ? mem[int'(rom_addr)] : 8'h00;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_start(input int c, input int a, input int e);
    sa[c] = AW'(a);
    ea[c] = AW'(e);
    start[c] = 1'b1;
    tick();
    start[c] = 1'b0;
  endtask
  task automatic do_stop(input int c);
    stop[c] = 1'b1;
    tick();
    stop[c] = 1'b0;
  endtask
  task automatic ex(input int c, input int nb, input int f);
    q.push_back({2'(c), 4'(nb), 1'(f)});
  endtask
  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 300);
    check("frame_done", 32'(frame_done), 32'd1);
    tick();
  endtask
  task automatic frame();
    cen_sr = 1'b1;
    tick();
    cen_sr = 1'b0;
    wait_frame();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      sa[i] = '0;
      ea[i] = '0;
    end
    mem[32'h100] = 8'hA5; mem[32'h101] = 8'h3C;
    mem[32'h300] = 8'h12; mem[32'h301] = 8'h9A;
    mem[32'h310] = 8'h34; mem[32'h320] = 8'h56;
    mem[32'h321] = 8'hBC; mem[32'h330] = 8'h78;
    mem[32'h400] = 8'hDE; mem[32'h410] = 8'hF1;
    mem[32'h500] = 8'h47; mem[32'h501] = 8'h89;
    mem[32'h200] = 8'hE2; mem[32'h3FFFF] = 8'h6B; mem[32'h0] = 8'hD4;
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rom_cs", 32'(rom_cs), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_nib", 32'({nib_vld, nib_ch, nib, nib_first}), 32'd0);
    check("rst_frame_overrun", 32'({frame_done, overrun}), 32'd0);
    rst = 1'b0;
    tick(2);
    // single channel, two-byte phrase
    do_start(0, 'h100, 'h101);
    check("t1_busy_start", 32'(busy), 32'h1);
    ex(0, 'hA, 1); ex(0, 'h5, 0); ex(0, 'h3, 0); ex(0, 'hC, 0);
    frame(); frame(); frame();
    check("t1_busy_before_last", 32'(busy), 32'h1);
    frame();
    check("t1_busy_after_last", 32'(busy), 32'h0);
    // four channels round robin, then idle channels skipped
    do_start(0, 'h300, 'h301);
    do_start(1, 'h310, 'h311);
    do_start(2, 'h320, 'h321);
    do_start(3, 'h330, 'h331);
    check("t2_busy_all", 32'(busy), 32'hF);
    ex(0, 1, 1); ex(1, 3, 1); ex(2, 5, 1); ex(3, 7, 1);
    frame();
    ex(0, 2, 0); ex(1, 4, 0); ex(2, 6, 0); ex(3, 8, 0);
    frame();
    do_stop(1);
    do_stop(3);
    check("t2_busy_after_stop", 32'(busy), 32'h5);
    ex(0, 9, 0); ex(2, 'hB, 0);
    frame();
    do_stop(0);
    do_stop(2);
    check("t2_busy_none", 32'(busy), 32'h0);
    // stop during an outstanding read
    rom_lat = 6;
    do_start(2, 'h400, 'h40F);
    do_start(3, 'h410, 'h41F);
    ex(3, 'hF, 1);
    cen_sr = 1'b1;
    tick();
    cen_sr = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rom_cs && rom_addr == AW'('h400)) && n < 300);
    check("t3_wait_ch2", 32'({rom_cs, rom_addr}), 32'({1'b1, 18'h400}));
    tick();
    do_stop(2);
    wait_frame();
    check("t3_busy", 32'(busy), 32'h8);
    do_stop(3);
    rom_lat = 2;
    // restart mid-phrase
    do_start(1, 'h500, 'h5FF);
    ex(1, 4, 1); ex(1, 7, 0); ex(1, 8, 0);
    frame(); frame(); frame();
    do_start(1, 'h200, 'h201);
    ex(1, 'hE, 1); ex(1, 2, 0);
    frame(); frame();
    check("t4_busy_restart", 32'(busy), 32'h2);
    do_stop(1);
    // address wrap from top of ROM to zero
    do_start(3, 'h3FFFF, 'h0);
    ex(3, 6, 1); ex(3, 'hB, 0); ex(3, 'hD, 0); ex(3, 4, 0);
    frame(); frame(); frame();
    check("t5_wrap_addr", 32'(rom_addr), 32'h0);
    check("t5_busy_mid", 32'(busy), 32'h8);
    frame();
    check("t5_busy_end", 32'(busy), 32'h0);
    check("t5_overrun_clear", 32'(overrun), 32'd0);
    // overrun and async reset in the middle of a read
    rom_lat = 20;
    do_start(0, 'h600, 'h6FF);
    for (int k = 0; k < 3; k++) begin
      cen_sr = 1'b1;
      tick();
      cen_sr = 1'b0;
      tick();
    end
    check("t6_overrun", 32'(overrun), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rom_cs && n < 300);
    check("t6_overrun_sticky", 32'({overrun, rom_cs}), 32'h3);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_rom", 32'({rom_cs, rom_addr}), 32'd0);
    check("t6_rst_nib", 32'({nib_vld, nib_ch, nib, nib_first, frame_done}), 32'd0);
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
